sobel_window_gen: RTL and testbench

Streaming 3x3 window generator that feeds the Sobel edge operator. It accepts 8-bit grayscale pixels in raster order, one per valid beat, and buffers the two previous image lines. From these it presents the nine registered window taps `mat00`..`mat22` plus a window-valid strobe and centre coordinates. It sits between the pixel source (camera or frame reader) and the combinational Sobel block, whose `mat` inputs it drives directly.

---
 rtl/sobel_window_gen.sv | 122 ++++++++++++
 tb/tb_sobel_window_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel operator: two line buffers plus a
// shifting 3x3 tap array, emitting only interior windows with their centre coordinates.
module sobel_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [7:0]       mat00,
    output logic [7:0]       mat01,
    output logic [7:0]       mat02,
    output logic [7:0]       mat10,
    output logic [7:0]       mat11,
    output logic [7:0]       mat12,
    output logic [7:0]       mat20,
    output logic [7:0]       mat21,
    output logic [7:0]       mat22,
    output logic             win_valid,
    output logic [COL_W-1:0] win_x,
    output logic [ROW_W-1:0] win_y,
    output logic             frame_done
);

    localparam int               AW       = $clog2(IMG_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col, cur_col, nxt_col;
    logic [ROW_W-1:0] row, cur_row, nxt_row;
    logic [AW-1:0]    addr;
    logic [7:0]       lb0 [IMG_W];
    logic [7:0]       lb1 [IMG_W];
    logic [7:0]       lb0_rd, lb1_rd;
    logic             first_pix, line_end, frame_end, win_done;

    // A qualified sof overrides the counters so the pixel is processed as (0,0).
    always_comb begin
        first_pix = pix_valid & sof;
        cur_col   = first_pix ? '0 : col;
        cur_row   = first_pix ? '0 : row;
        addr      = cur_col[AW-1:0];
        lb0_rd    = lb0[addr];
        lb1_rd    = lb1[addr];
        line_end  = (cur_col == LAST_COL);
        frame_end = line_end && (cur_row == LAST_ROW);
        win_done  = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
        nxt_col   = line_end ? '0 : cur_col + COL_W'(1);
        if (!line_end)
            nxt_row = cur_row;
        else if (cur_row == LAST_ROW)
            nxt_row = '0;
        else
            nxt_row = cur_row + ROW_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            col <= nxt_col;
            row <= nxt_row;
        end
    end

    // NOTE: line buffers are deliberately not reset; rows 0/1 of every frame overwrite
    // them before any valid window reads them, and omitting reset keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[addr] <= lb0_rd;
            lb0[addr] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat00 <= '0;
            mat01 <= '0;
            mat02 <= '0;
            mat10 <= '0;
            mat11 <= '0;
            mat12 <= '0;
            mat20 <= '0;
            mat21 <= '0;
            mat22 <= '0;
        end else if (pix_valid) begin
            mat00 <= mat01;
            mat01 <= mat02;
            mat02 <= lb1_rd;
            mat10 <= mat11;
            mat11 <= mat12;
            mat12 <= lb0_rd;
            mat20 <= mat21;
            mat21 <= mat22;
            mat22 <= pix_in;
        end
    end

    // Strobes drop on any cycle without a completing beat; coordinates hold until the next window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= pix_valid && win_done;
            frame_done <= pix_valid && frame_end;
            if (pix_valid && win_done) begin
                win_x <= cur_col - COL_W'(1);
                win_y <= cur_row - ROW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 image: table of expected windows
// compared against windows captured by a negedge monitor, plus multi-cycle corner sequences.
module tb_sobel_window_gen;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       sof;
    logic [7:0] mat00, mat01, mat02, mat10, mat11, mat12, mat20, mat21, mat22;
    logic       win_valid;
    logic [2:0] win_x;
    logic [1:0] win_y;
    logic       frame_done;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .COL_W(3), .ROW_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .mat00(mat00), .mat01(mat01), .mat02(mat02),
        .mat10(mat10), .mat11(mat11), .mat12(mat12),
        .mat20(mat20), .mat21(mat21), .mat22(mat22),
        .win_valid(win_valid), .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] taps;
        int          x;
        int          y;
        int          pix;
    } cap_t;

    // Expected window record: completing pixel index, centre, raster index of tap mat00.
    typedef struct {
        int pix;
        int x;
        int y;
        int tl;
    } vec_t;

    cap_t win_q[$];
    int   fd_q[$];
    int   beats = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t tab[6];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (win_valid)
                win_q.push_back('{taps: {mat00, mat01, mat02, mat10, mat11, mat12, mat20, mat21, mat22},
                                  x: int'(win_x), y: int'(win_y), pix: beats - 1});
            if (frame_done)
                fd_q.push_back(beats - 1);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic beat(input int v, input logic s);
        pix_in    = 8'(v);
        sof       = s;
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        beats++;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int base, input logic first_sof, input int gap);
        for (int i = 0; i < W * H; i++) begin
            beat(base + i, first_sof && (i == 0));
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic clear_caps();
        win_q.delete();
        fd_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, " mat00"}, int'(mat00), 0);
        check({tag, " mat01"}, int'(mat01), 0);
        check({tag, " mat02"}, int'(mat02), 0);
        check({tag, " mat10"}, int'(mat10), 0);
        check({tag, " mat11"}, int'(mat11), 0);
        check({tag, " mat12"}, int'(mat12), 0);
        check({tag, " mat20"}, int'(mat20), 0);
        check({tag, " mat21"}, int'(mat21), 0);
        check({tag, " mat22"}, int'(mat22), 0);
        check({tag, " win_valid"}, int'(win_valid), 0);
        check({tag, " win_x"}, int'(win_x), 0);
        check({tag, " win_y"}, int'(win_y), 0);
        check({tag, " frame_done"}, int'(frame_done), 0);
    endtask

    // Compare six captured windows starting at queue slot qi against the table,
    // with pixel values offset by base and pixel indices offset by beat index off.
    task automatic check_windows(input int qi, input int base, input int off, input string tag);
        cap_t c;
        for (int k = 0; k < 6; k++) begin
            if (qi + k >= win_q.size()) begin
                check($sformatf("%s w%0d captured (queue size)", tag, k), win_q.size(), qi + k + 1);
                continue;
            end
            c = win_q[qi + k];
            check($sformatf("%s w%0d pix", tag, k), c.pix, off + tab[k].pix);
            check($sformatf("%s w%0d win_x", tag, k), c.x, tab[k].x);
            check($sformatf("%s w%0d win_y", tag, k), c.y, tab[k].y);
            for (int r = 0; r < 3; r++)
                for (int cc = 0; cc < 3; cc++)
                    check($sformatf("%s w%0d mat%0d%0d", tag, k, r, cc),
                          int'(c.taps[(8 - (r * 3 + cc)) * 8 +: 8]), base + tab[k].tl + r * W + cc);
        end
    endtask

    task automatic check_fd(input int n, input int idx, input int exp, input string tag);
        check({tag, " frame_done count"}, fd_q.size(), n);
        if (idx < fd_q.size())
            check({tag, " frame_done beat"}, fd_q[idx], exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        tab = '{'{12, 1, 1, 0}, '{13, 2, 1, 1}, '{14, 3, 1, 2},
                '{17, 1, 2, 5}, '{18, 2, 2, 6}, '{19, 3, 2, 7}};

        rst_n     = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        idle(2);
        check_zero("reset");
        rst_n = 1'b1;
        idle(1);

        // 1: ungapped frame with sof on pixel 0
        clear_caps();
        t0 = beats;
        frame(0, 1'b1, 0);
        idle(2);
        check("t1 window count", win_q.size(), 6);
        check_windows(0, 0, t0, "t1");
        check_fd(1, 0, t0 + 19, "t1");

        // 2: pix_valid every other cycle; taps hold between strobes
        clear_caps();
        t0 = beats;
        for (int i = 0; i < W * H; i++) begin
            beat(i, i == 0);
            idle(1);
            if (i == 12) begin
                check("t2 hold win_valid", int'(win_valid), 0);
                check("t2 hold mat00", int'(mat00), 0);
                check("t2 hold mat11", int'(mat11), 6);
                check("t2 hold mat22", int'(mat22), 12);
                check("t2 hold win_x", int'(win_x), 1);
            end
        end
        idle(2);
        check("t2 window count", win_q.size(), 6);
        check_windows(0, 0, t0, "t2");
        check_fd(1, 0, t0 + 19, "t2");
        check("t2 end hold mat22", int'(mat22), 19);

        // 3: two frames back-to-back, second without sof
        clear_caps();
        t0 = beats;
        frame(0, 1'b1, 0);
        frame(100, 1'b0, 0);
        idle(2);
        check("t3 window count", win_q.size(), 12);
        check_windows(0, 0, t0, "t3f1");
        check_windows(6, 100, t0 + 20, "t3f2");
        check_fd(2, 0, t0 + 19, "t3");
        check_fd(2, 1, t0 + 39, "t3b");

        // 4: sof at pixel 8 truncates the frame
        clear_caps();
        for (int i = 0; i < 8; i++) beat(i, i == 0);
        t1 = beats;
        frame(50, 1'b1, 0);
        idle(2);
        check("t4 window count", win_q.size(), 6);
        check_windows(0, 50, t1, "t4");
        check_fd(1, 0, t1 + 19, "t4");

        // 5: asynchronous reset mid-frame, then a frame without sof
        clear_caps();
        for (int i = 0; i < 13; i++) beat(i, i == 0);
        idle(1);
        check("t5 windows before reset", win_q.size(), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t5 reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        clear_caps();
        t1 = beats;
        frame(30, 1'b0, 0);
        idle(2);
        check("t5 window count", win_q.size(), 6);
        check_windows(0, 30, t1, "t5");
        check_fd(1, 0, t1 + 19, "t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
